// File: rtl/imm_extend_pipe_pkg.sv
// Shared immediate-format encoding and instruction field positions for the decode stage.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I   = 3'd0,
        IMM_S   = 3'd1,
        IMM_B   = 3'd2,
        IMM_U   = 3'd3,
        IMM_J   = 3'd4,
        IMM_Z   = 3'd5,
        IMM_SH  = 3'd6,
        IMM_RSV = 3'd7
    } imm_src_e;

    // Low bit of each register/funct field, shared with the instruction decoder.
    localparam int RD_LSB     = 7;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// Combinational immediate extractor: {instr, imm_src} -> XLEN-wide extended immediate.
// Also usable directly by a single-cycle core.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_src_e        imm_src,
    output logic [XLEN-1:0] imm_ext,
    output logic            imm_err
);

    logic s;
    logic unused_opcode;

    assign s             = instr[31];
    assign unused_opcode = ^instr[6:0];

    // Every signed format is first assembled as a 32-bit value, then widened by sign.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    always_comb begin
        imm_ext = '0;
        imm_err = 1'b0;
        case (imm_src)
            IMM_I:  imm_ext = sext32({{20{s}}, instr[31:RS2_LSB]});
            IMM_S:  imm_ext = sext32({{20{s}}, instr[31:FUNCT7_LSB], instr[RD_LSB +: 5]});
            IMM_B:  imm_ext = sext32({{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0});
            IMM_U:  imm_ext = sext32({instr[31:12], 12'b0});
            IMM_J:  imm_ext = sext32({{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0});
            IMM_Z:  imm_ext = XLEN'(instr[RS1_LSB +: 5]);
            IMM_SH: begin
                if (XLEN == 64) imm_ext = XLEN'(instr[RS2_LSB +: 6]);
                else            imm_ext = XLEN'(instr[RS2_LSB +: 5]);
            end
            default: imm_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage pipelined immediate generator with valid/ready on both sides and a synchronous flush.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      Instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [XLEN-1:0]  ImmExt,
    output logic             ImmErr,
    output logic [TAG_W-1:0] OutTag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    logic             s1_valid;
    logic [31:0]      s1_instr;
    imm_src_e         s1_src;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_load;
    logic             in_fire;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;

    // Handshake: a word moves on an edge where valid && ready on that side; the producer
    // may drop valid at any time while ready is low, and ready never looks at valid.
    assign s2_load = s1_valid && (!OutValid || OutReady);
    assign InReady = !s1_valid || s2_load;
    assign in_fire = InValid && InReady;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (s1_instr),
        .imm_src (s1_src),
        .imm_ext (dec_imm),
        .imm_err (dec_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_src   <= IMM_I;
            s1_tag   <= '0;
            OutValid <= 1'b0;
            ImmExt   <= '0;
            ImmErr   <= 1'b0;
            OutTag   <= '0;
        end else if (Flush) begin
            // Kill both stages; data registers keep whatever they held.
            s1_valid <= 1'b0;
            OutValid <= 1'b0;
        end else begin
            if (InReady) s1_valid <= InValid;
            if (in_fire) begin
                s1_instr <= Instr;
                s1_src   <= imm_src_e'(ImmSrc);
                s1_tag   <= InTag;
            end
            if (s2_load) begin
                OutValid <= 1'b1;
                ImmExt   <= dec_imm;
                ImmErr   <= dec_err;
                OutTag   <= s1_tag;
            end else if (OutReady) begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share stimulus; a queue scoreboard
// fed by an arithmetic immediate model checks every output cycle.
module tb_imm_extend_pipe;

    localparam int W = 102; // {exp32[31:0], exp64[63:0], err, tag[4:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] instr = '0;
    logic [2:0]  imm_src = '0;
    logic [4:0]  in_tag = '0;

    logic        in_ready32, in_ready64, out_valid32, out_valid64;
    logic        err32, err64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en = 1'b0;
    bit          m_s1 = 1'b0;
    bit          m_s2 = 1'b0;
    bit          last_acc = 1'b0;
    int          dut_acc = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_exp = '0;

    logic [31:0] d_ins[9];
    logic [2:0]  d_src[9];
    logic [31:0] d_e32[9];
    logic [63:0] d_e64[9];
    bit          d_err[9];

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(in_ready32),
        .Instr(instr), .ImmSrc(imm_src), .InTag(in_tag), .OutValid(out_valid32),
        .OutReady(out_ready), .ImmExt(imm32), .ImmErr(err32), .OutTag(tag32)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(in_ready64),
        .Instr(instr), .ImmSrc(imm_src), .InTag(in_tag), .OutValid(out_valid64),
        .OutReady(out_ready), .ImmExt(imm64), .ImmErr(err64), .OutTag(tag64)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sx(input longint x, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (x >= half) ? x - (half << 1) : x;
    endfunction

    // Immediate value as a number, built by weighting each field by its bit position.
    function automatic void ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen,
                                    output logic [63:0] val, output bit err);
        longint v;
        err = 1'b0;
        case (src)
            3'd0: v = sx(longint'(ins[31:20]), 12);
            3'd1: v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            3'd2: v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                         + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            3'd3: v = sx(longint'(ins[31:12]) * 4096, 32);
            3'd4: v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                         + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: begin
                v   = 0;
                err = 1'b1;
            end
        endcase
        val = (xlen == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
    endfunction

    function automatic bit m_ready();
        return !m_s1 || !m_s2 || out_ready;
    endfunction

    // ---------------- scoreboard / reference pipeline ----------------
    always @(posedge clk or negedge rst_n) begin
        bit rdy;
        bit s2l;
        if (!rst_n) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            last_acc = 1'b0;
            exp_q.delete();
        end else begin
            rdy = m_ready();
            s2l = m_s1 && (!m_s2 || out_ready);
            last_acc = in_valid && rdy && !flush;
            if (flush) begin
                m_s1 = 1'b0;
                m_s2 = 1'b0;
                exp_q.delete();
            end else begin
                if (m_s2 && out_ready) void'(exp_q.pop_front());
                m_s2 = s2l || (m_s2 && !out_ready);
                if (rdy) m_s1 = in_valid;
                if (last_acc) exp_q.push_back(cur_exp);
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && mon_en) begin
            if (in_valid && in_ready32) dut_acc++;
            check("in_ready32", 64'(in_ready32), 64'(m_ready()));
            check("in_ready64", 64'(in_ready64), 64'(m_ready()));
            check("out_valid32", 64'(out_valid32), 64'(m_s2));
            check("out_valid64", 64'(out_valid64), 64'(m_s2));
            if (m_s2 && exp_q.size() > 0) begin
                e = exp_q[0];
                check("imm32", 64'(imm32), 64'(e[101:70]));
                check("imm64", imm64, e[69:6]);
                check("err32", 64'(err32), 64'(e[5]));
                check("err64", 64'(err64), 64'(e[5]));
                check("tag32", 64'(tag32), 64'(e[4:0]));
                check("tag64", 64'(tag64), 64'(e[4:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // dir=1 takes the word and expected values from the table, otherwise random + model.
    task automatic present(input bit dir, input int di, input logic [4:0] tag);
        logic [63:0] v32, v64;
        bit e32, e64;
        in_valid = 1'b1;
        in_tag   = tag;
        if (dir) begin
            instr   = d_ins[di];
            imm_src = d_src[di];
            cur_exp = {d_e32[di], d_e64[di], d_err[di], tag};
        end else begin
            instr   = $urandom;
            imm_src = 3'($urandom_range(0, 7));
            ref_imm(instr, imm_src, 32, v32, e32);
            ref_imm(instr, imm_src, 64, v64, e64);
            cur_exp = {v32[31:0], v64, e32, tag};
        end
    endtask

    task automatic send(input bit dir, input int di, input logic [4:0] tag);
        present(dir, di, tag);
        for (int c = 0; c < 50; c++) begin
            step();
            if (last_acc) break;
        end
        check("accept", 64'(last_acc), 64'(1));
    endtask

    task automatic measure_latency(input string tag);
        int lat;
        lat = 1;
        while (!out_valid32 && lat < 10) begin
            step();
            lat++;
        end
        check(tag, 64'(lat), 64'(2));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        step();
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        check("drain_ov", 64'(out_valid32), 64'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int idx;
        d_ins = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7, 32'h80000037,
                  32'h001000EF, 32'h000FD073, 32'h03F01013, 32'hDEADBEEF};
        d_src = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        d_e32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h80000000,
                  32'h00000800, 32'h0000001F, 32'h0000001F, 32'h00000000};
        d_e64 = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'hFFFFFFFF_FFFFFFF8,
                  64'h00000000_12345000, 64'hFFFFFFFF_80000000, 64'h00000000_00000800,
                  64'h00000000_0000001F, 64'h00000000_0000003F, 64'h00000000_00000000};
        d_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ov32", 64'(out_valid32), 64'(0));
        check("rst_imm32", 64'(imm32), 64'(0));
        check("rst_imm64", imm64, 64'(0));
        check("rst_err32", 64'(err32), 64'(0));
        check("rst_tag32", 64'(tag32), 64'(0));
        check("rst_ready32", 64'(in_ready32), 64'(1));
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // single word latency, then all directed formats back-to-back
        send(1'b1, 0, 5'd0);
        in_valid = 1'b0;
        measure_latency("latency_first");
        drain();
        for (int i = 0; i < 9; i++) send(1'b1, i, 5'(i));
        drain();

        // backpressure: 5 stalled cycles, 4 back-to-back words tagged 0..3
        out_ready = 1'b0;
        dut_acc   = 0;
        idx       = 0;
        present(1'b0, 0, 5'd0);
        for (int c = 0; c < 40; c++) begin
            if (c == 5) begin
                check("bp_two_accepted", 64'(dut_acc), 64'(2));
                out_ready = 1'b1;
            end
            if (idx >= 4 && exp_q.size() == 0) break;
            step();
            if (last_acc) begin
                idx++;
                if (idx < 4) present(1'b0, 0, 5'(idx));
                else in_valid = 1'b0;
            end
        end
        check("bp_all_sent", 64'(idx), 64'(4));
        drain();

        // flush with both stages full and a word presented
        out_ready = 1'b0;
        send(1'b0, 0, 5'd1);
        send(1'b0, 0, 5'd2);
        present(1'b0, 0, 5'd3);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_ov32", 64'(out_valid32), 64'(0));
        check("flush_ov64", 64'(out_valid64), 64'(0));
        out_ready = 1'b1;
        send(1'b1, 3, 5'd4);
        in_valid = 1'b0;
        measure_latency("latency_after_flush");
        drain();

        // asynchronous reset between edges with a result on the output
        out_ready = 1'b0;
        send(1'b1, 0, 5'd9);
        send(1'b1, 3, 5'd10);
        in_valid = 1'b0;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ov32", 64'(out_valid32), 64'(0));
        check("arst_ov64", 64'(out_valid64), 64'(0));
        check("arst_imm32", 64'(imm32), 64'(0));
        check("arst_imm64", imm64, 64'(0));
        check("arst_err32", 64'(err32), 64'(0));
        check("arst_tag32", 64'(tag32), 64'(0));
        check("arst_tag64", 64'(tag64), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(1'b1, 5, 5'd11);
        in_valid = 1'b0;
        measure_latency("latency_after_reset");
        drain();

        // random traffic with random backpressure, gaps and occasional flush
        for (int c = 0; c < 1500; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 4) != 0) present(1'b0, 0, 5'($urandom_range(0, 31)));
            else in_valid = 1'b0;
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
